// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative MULU and optional DIVU/REMU
// Optional divider datapath enabled by defining ALU_MC_DIV_EN.
module alu_mc #(
    parameter int W     = 8,
    parameter int IMM_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             typeCode,
    input  logic [3:0]       rOp,
    input  logic [2:0]       iOp,
    input  logic             mdEn,
    input  logic [1:0]       mdOp,
    input  logic [W-1:0]     acc,
    input  logic [W-1:0]     opReg,
    input  logic [IMM_W-1:0] imm,
    input  logic             scIn,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     rslt,
    output logic [W-1:0]     rsltHi,
    output logic             scOut,
    output logic             zero,
    output logic             branch,
    output logic             dz
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W + 1);
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;
    localparam logic [1:0] MD_MULU = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;

    logic            state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    opnd;
    logic [2*W-1:0]  work;
`ifdef ALU_MC_DIV_EN
    logic [1:0]      mdSel;
`endif

    logic [W-1:0]    zImm, scR;
    logic            scC, scBr, scDz, isMulti;
    logic [W:0]      wide;
    logic [SW-1:0]   rSh, iSh;

    assign zImm = {{(W-IMM_W){1'b0}}, imm};
    assign rSh  = opReg[SW-1:0];
    assign iSh  = imm[SW-1:0];
    assign busy = (state == STATE_RUN);

    always_comb begin
        scR     = '0;
        scC     = 1'b0;
        scBr    = 1'b0;
        scDz    = 1'b0;
        isMulti = 1'b0;
        wide    = '0;
        if (mdEn) begin
            case (mdOp)
                MD_MULU: isMulti = 1'b1;
                MD_DIVU, MD_REMU: begin
`ifdef ALU_MC_DIV_EN
                    isMulti = 1'b1;
`else
                    scR  = '1;
                    scDz = 1'b1;
`endif
                end
                default: scR = '0;
            endcase
        end else if (!typeCode) begin
            case (rOp)
                4'b0000: begin
                    wide = {1'b0, acc} + {1'b0, opReg} + {{W{1'b0}}, scIn};
                    scR  = wide[W-1:0];
                    scC  = wide[W];
                end
                4'b0001: begin
                    wide = {1'b0, acc} - {1'b0, opReg} - {{W{1'b0}}, scIn};
                    scR  = wide[W-1:0];
                    scC  = wide[W];
                end
                4'b0010: scR = acc & opReg;
                4'b0011: scR = acc | opReg;
                4'b0100: scR = acc ^ opReg;
                4'b0101: scR = {{(W-1){1'b0}}, ^opReg};
                4'b0110: scR = acc << rSh;
                4'b0111: scR = acc >> rSh;
                4'b1010: scR = {{(W-1){1'b0}}, acc == opReg};
                4'b1011: scR = {{(W-1){1'b0}}, $signed(acc) < $signed(opReg)};
                4'b1100: begin
                    scR  = acc;
                    scBr = |acc;
                end
                4'b1101: begin
                    scR  = opReg;
                    scBr = 1'b1;
                end
                4'b1110: scR = acc;
                default: scR = opReg;
            endcase
        end else begin
            case (iOp)
                3'b000: begin
                    wide = {1'b0, acc} + {1'b0, zImm} + {{W{1'b0}}, scIn};
                    scR  = wide[W-1:0];
                    scC  = wide[W];
                end
                3'b001: begin
                    wide = {1'b0, acc} - {1'b0, zImm} - {{W{1'b0}}, scIn};
                    scR  = wide[W-1:0];
                    scC  = wide[W];
                end
                3'b010:  scR = acc & zImm;
                3'b011:  scR = acc << iSh;
                3'b100:  scR = acc >> iSh;
                3'b101:  scR = zImm;
                default: scR = '0;
            endcase
        end
    end

    // work holds {partial product, multiplier} for MULU and {remainder, quotient} for divides
    logic [W:0]      mulSum;
    logic [2*W-1:0]  mulNext, workNext;
    logic [W-1:0]    finLo, finHi;
    logic            finDz;

    assign mulSum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    assign mulNext = {mulSum, work[W-1:1]};

`ifdef ALU_MC_DIV_EN
    logic [W:0]      divShift, divDiff;
    logic [2*W-1:0]  divNext;

    assign divShift = work[2*W-1:W-1];
    assign divDiff  = divShift - {1'b0, opnd};
    assign divNext  = divDiff[W] ? {divShift[W-1:0], work[W-2:0], 1'b0}
                                 : {divDiff[W-1:0],  work[W-2:0], 1'b1};

    always_comb begin
        workNext = (mdSel == MD_MULU) ? mulNext : divNext;
        finHi    = '0;
        finDz    = 1'b0;
        if (mdSel == MD_MULU) begin
            finLo = mulNext[W-1:0];
            finHi = mulNext[2*W-1:W];
        end else if (mdSel == MD_DIVU) begin
            finLo = divNext[W-1:0];
            finDz = (opnd == '0);
        end else begin
            finLo = divNext[2*W-1:W];
            finDz = (opnd == '0);
        end
    end
`else
    always_comb begin
        workNext = mulNext;
        finLo    = mulNext[W-1:0];
        finHi    = mulNext[2*W-1:W];
        finDz    = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= STATE_IDLE;
            cnt    <= '0;
            opnd   <= '0;
            work   <= '0;
            done   <= 1'b0;
            rslt   <= '0;
            rsltHi <= '0;
            scOut  <= 1'b0;
            zero   <= 1'b0;
            branch <= 1'b0;
            dz     <= 1'b0;
`ifdef ALU_MC_DIV_EN
            mdSel  <= MD_MULU;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (start && isMulti) begin
                        state <= STATE_RUN;
                        cnt   <= CW'(W);
`ifdef ALU_MC_DIV_EN
                        mdSel <= mdOp;
`endif
                        if (mdOp == MD_MULU) begin
                            opnd <= acc;
                            work <= {{W{1'b0}}, opReg};
                        end else begin
                            opnd <= opReg;
                            work <= {{W{1'b0}}, acc};
                        end
                    end else if (start) begin
                        rslt   <= scR;
                        rsltHi <= '0;
                        scOut  <= scC;
                        zero   <= (scR == '0);
                        branch <= scBr;
                        dz     <= scDz;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    work <= workNext;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= STATE_IDLE;
                        rslt   <= finLo;
                        rsltHi <= finHi;
                        scOut  <= 1'b0;
                        zero   <= (finLo == '0);
                        branch <= 1'b0;
                        dz     <= finDz;
                        done   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc against an arithmetic reference model
module tb_alu_mc;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       typeCode = 1'b0;
    logic [3:0] rOp = '0;
    logic [2:0] iOp = '0;
    logic       mdEn = 1'b0;
    logic [1:0] mdOp = '0;
    logic [7:0] acc = '0;
    logic [7:0] opReg = '0;
    logic [4:0] imm = '0;
    logic       scIn = 1'b0;
    logic       busy, done, scOut, zero, branch, dz;
    logic [7:0] rslt, rsltHi;

    alu_mc #(.W(8), .IMM_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .typeCode(typeCode),
        .rOp(rOp), .iOp(iOp), .mdEn(mdEn), .mdOp(mdOp), .acc(acc), .opReg(opReg),
        .imm(imm), .scIn(scIn), .busy(busy), .done(done), .rslt(rslt),
        .rsltHi(rsltHi), .scOut(scOut), .zero(zero), .branch(branch), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] hi;
        logic       sc;
        logic       z;
        logic       br;
        logic       dzv;
        int         edgeAt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic tc, input logic [3:0] r, input logic [2:0] i,
                                   input logic md, input logic [1:0] mo, input int a, input int b,
                                   input int im, input int c, output bit multi);
        exp_t e;
        int   s, sa, sb2, q, rm;
        e = '{default: 0};
        multi = 0;
        if (md) begin
            case (mo)
                2'd0: begin
                    multi = 1;
                    s = a * b;
                    e.r = 8'(s % 256);
                    e.hi = 8'(s / 256);
                end
                2'd1, 2'd2: begin
`ifdef ALU_MC_DIV_EN
                    multi = 1;
                    if (b == 0) begin
                        q = 255; rm = a; e.dzv = 1;
                    end else begin
                        q = a / b; rm = a % b;
                    end
                    e.r = 8'((mo == 2'd1) ? q : rm);
`else
                    e.r = 8'd255;
                    e.dzv = 1;
`endif
                end
                default: e.r = 8'd0;
            endcase
        end else if (!tc) begin
            sa  = (a > 127) ? a - 256 : a;
            sb2 = (b > 127) ? b - 256 : b;
            case (r)
                4'd0:  begin s = a + b + c; e.r = 8'(s); e.sc = (s > 255); end
                4'd1:  begin s = a - b - c; e.r = 8'(s); e.sc = (s < 0); end
                4'd2:  e.r = 8'(a & b);
                4'd3:  e.r = 8'(a | b);
                4'd4:  e.r = 8'(a ^ b);
                4'd5:  e.r = 8'($countones(b) % 2);
                4'd6:  e.r = 8'((a * (2 ** (b % 8))) % 256);
                4'd7:  e.r = 8'(a / (2 ** (b % 8)));
                4'd10: e.r = 8'(a == b);
                4'd11: e.r = 8'(sa < sb2);
                4'd12: begin e.r = 8'(a); e.br = (a != 0); end
                4'd13: begin e.r = 8'(b); e.br = 1; end
                4'd14: e.r = 8'(a);
                default: e.r = 8'(b);
            endcase
        end else begin
            case (i)
                3'd0: begin s = a + im + c; e.r = 8'(s); e.sc = (s > 255); end
                3'd1: begin s = a - im - c; e.r = 8'(s); e.sc = (s < 0); end
                3'd2: e.r = 8'(a & im);
                3'd3: e.r = 8'((a * (2 ** (im % 8))) % 256);
                3'd4: e.r = 8'(a / (2 ** (im % 8)));
                3'd5: e.r = 8'(im);
                default: e.r = 8'd0;
            endcase
        end
        e.z = (e.r == 0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done pulsed at edge %0d with nothing outstanding", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_edge", cyc, e.edgeAt);
                chk("rslt", rslt, e.r);
                chk("rsltHi", rsltHi, e.hi);
                chk("scOut", scOut, e.sc);
                chk("zero", zero, e.z);
                chk("branch", branch, e.br);
                chk("dz", dz, e.dzv);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic launch(input logic tc, input logic [3:0] r, input logic [2:0] i,
                          input logic md, input logic [1:0] mo, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] im, input logic c,
                          input bit push, output bit multi);
        exp_t e;
        @(negedge clk);
        e = model(tc, r, i, md, mo, int'(a), int'(b), int'(im), int'(c), multi);
        e.edgeAt = cyc + 1 + (multi ? W : 0);
        if (push) sb.push_back(e);
        typeCode = tc; rOp = r; iOp = i; mdEn = md; mdOp = mo;
        acc = a; opReg = b; imm = im; scIn = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk(multi ? "busy_run" : "busy_single", busy, multi);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic rop(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b, input logic c);
        bit m;
        launch(1'b0, r, 3'd0, 1'b0, 2'd0, a, b, 5'd0, c, 1, m);
        waitIdle();
    endtask

    task automatic iop(input logic [2:0] i, input logic [7:0] a, input logic [4:0] im, input logic c);
        bit m;
        launch(1'b1, 4'd0, i, 1'b0, 2'd0, a, 8'd0, im, c, 1, m);
        waitIdle();
    endtask

    task automatic mdo(input logic [1:0] mo, input logic [7:0] a, input logic [7:0] b);
        bit m;
        launch(1'b0, 4'd0, 3'd0, 1'b1, mo, a, b, 5'd0, 1'b0, 1, m);
        waitIdle();
    endtask

    initial begin
        bit m;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {busy, done, rslt, rsltHi, scOut, zero, branch, dz}, 0);
        reset_n = 1'b1;

        rop(4'd0, 8'd44, 8'd45, 1'b0);
        rop(4'd1, 8'd44, 8'd45, 1'b0);
        mdo(2'd0, 8'd200, 8'd3);
        mdo(2'd0, 8'd255, 8'd255);
        mdo(2'd1, 8'd100, 8'd7);
        mdo(2'd2, 8'd100, 8'd7);
        mdo(2'd1, 8'd44, 8'd0);
        mdo(2'd3, 8'd9, 8'd9);
        rop(4'd12, 8'd1, 8'd0, 1'b0);
        rop(4'd12, 8'd0, 8'd5, 1'b0);
        rop(4'd13, 8'd0, 8'd77, 1'b0);
        rop(4'd11, 8'h80, 8'd1, 1'b0);

        // start pulse with new operands mid-multiply must be ignored
        launch(1'b0, 4'd0, 3'd0, 1'b1, 2'd0, 8'd200, 8'd3, 5'd0, 1'b0, 1, m);
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc = 8'd99; mdEn = 1'b0; rOp = 4'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle();

        // reset four edges into a long operation aborts it without a done pulse
`ifdef ALU_MC_DIV_EN
        launch(1'b0, 4'd0, 3'd0, 1'b1, 2'd1, 8'd100, 8'd7, 5'd0, 1'b0, 0, m);
`else
        launch(1'b0, 4'd0, 3'd0, 1'b1, 2'd0, 8'd100, 8'd7, 5'd0, 1'b0, 0, m);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outs", {busy, done, rslt, rsltHi, scOut, zero, branch, dz}, 0);
        reset_n = 1'b1;
        iop(3'd5, 8'd0, 5'd25, 1'b0);

        for (int k = 0; k < 150; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                mdo(2'($urandom), a, b);
            else if ($urandom_range(0, 1) == 0)
                rop(4'($urandom), a, b, 1'($urandom));
            else
                iop(3'($urandom), a, 5'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
